// File: rtl/n_clic_stack.sv
// n_clic_stack: multi-level nested interrupt controller with a hardware return stack.
// Optional macro N_CLIC_TAIL_CHAIN_EN lets a return chain directly into the next eligible handler.

package n_clic_pkg;
    typedef enum logic [2:0] {
        CSR_NONE = 3'b000,
        CSR_RW   = 3'b001,
        CSR_RS   = 3'b010,
        CSR_RC   = 3'b011,
        CSR_RWI  = 3'b101,
        CSR_RSI  = 3'b110,
        CSR_RCI  = 3'b111
    } csr_op_t;

    typedef enum logic {
        PC_NORMAL    = 1'b0,
        PC_INTERRUPT = 1'b1
    } pc_interrupt_mux_t;
endpackage

module n_clic_stack
    import n_clic_pkg::*;
#(
    parameter int          VecCount   = 8,
    parameter int          PrioWidth  = 3,
    parameter int          StackDepth = 4,
    parameter int          AddrWidth  = 12,
    parameter logic [11:0] CsrBase    = 12'hB00,
    parameter logic [11:0] CsrVecBase = 12'hB40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    csr_enable,
    input  logic [11:0]             csr_addr,
    input  csr_op_t                 csr_op,
    input  logic [4:0]              rs1_zimm,
    input  logic [31:0]             rs1_data,
    input  logic [VecCount-1:0]     irq,
    input  logic                    ret,
    input  logic [AddrWidth-1:0]    pc_in,
    output logic [31:0]             csr_out,
    output logic [AddrWidth-1:0]    int_addr,
    output pc_interrupt_mux_t       pc_interrupt_sel,
    output logic [PrioWidth-1:0]    level_out,
    output logic                    interrupt_out
);
    localparam int DepthW = $clog2(StackDepth + 1);
    localparam int IdxW   = (StackDepth > 1) ? $clog2(StackDepth) : 1;
    localparam int VecW   = (VecCount > 1) ? $clog2(VecCount) : 1;

    logic [VecCount-1:0]  pending, enable, irq_q, pend_next;
    logic [PrioWidth-1:0] prio    [VecCount];
    logic [AddrWidth-1:0] handler [VecCount];
    logic [AddrWidth-1:0] stack_pc  [StackDepth];
    logic [PrioWidth-1:0] stack_lvl [StackDepth];
    logic [DepthW-1:0]    depth;
    logic [PrioWidth-1:0] level;

    logic [2:0]           op_bits;
    logic [31:0]          operand, csr_rdata, csr_wdata;
    logic                 csr_we;
    logic [VecCount-1:0]  cfg_sel, vec_sel;
    logic [IdxW-1:0]      top_idx, push_idx;
    logic [PrioWidth-1:0] threshold, best;
    logic [VecW-1:0]      winner;
    logic                 found, do_take, do_pop, do_chain;
    logic                 unused_wdata;

    assign op_bits      = csr_op;
    assign operand      = op_bits[2] ? {27'b0, rs1_zimm} : rs1_data;
    assign top_idx      = IdxW'(depth - 1'b1);
    assign push_idx     = IdxW'(depth);
    assign level_out    = level;
    assign csr_out      = csr_enable ? csr_rdata : 32'b0;
    assign unused_wdata = ^csr_wdata;

    always_comb begin
        cfg_sel   = '0;
        vec_sel   = '0;
        csr_rdata = '0;
        for (int i = 0; i < VecCount; i++) begin
            if (csr_addr == CsrBase + 12'(i)) begin
                cfg_sel[i] = 1'b1;
                csr_rdata  = 32'({prio[i], enable[i], pending[i]});
            end
            if (csr_addr == CsrVecBase + 12'(i)) begin
                vec_sel[i] = 1'b1;
                csr_rdata  = 32'(handler[i]);
            end
        end
    end

    // Set/clear forms with a zero operand are pure reads.
    always_comb begin
        csr_wdata = operand;
        csr_we    = 1'b0;
        case (op_bits[1:0])
            2'b01: begin
                csr_wdata = operand;
                csr_we    = csr_enable;
            end
            2'b10: begin
                csr_wdata = csr_rdata | operand;
                csr_we    = csr_enable && (operand != '0);
            end
            2'b11: begin
                csr_wdata = csr_rdata & ~operand;
                csr_we    = csr_enable && (operand != '0);
            end
            default: ;
        endcase
    end

    // Strictly-greater compare in index order gives the lowest index on a priority tie.
    always_comb begin
        threshold = level;
`ifdef N_CLIC_TAIL_CHAIN_EN
        if (ret && depth != '0) threshold = stack_lvl[top_idx];
`endif
        found  = 1'b0;
        winner = '0;
        best   = '0;
        for (int i = 0; i < VecCount; i++) begin
            if (pending[i] && enable[i] && (prio[i] > threshold) && (!found || prio[i] > best)) begin
                found  = 1'b1;
                winner = VecW'(i);
                best   = prio[i];
            end
        end
    end

    always_comb begin
        do_take  = 1'b0;
        do_pop   = 1'b0;
        do_chain = 1'b0;
        if (ret && depth != '0) begin
`ifdef N_CLIC_TAIL_CHAIN_EN
            if (found) do_chain = 1'b1;
            else       do_pop   = 1'b1;
`else
            do_pop = 1'b1;
`endif
        end else if (!ret && found && depth < DepthW'(StackDepth)) begin
            do_take = 1'b1;
        end

        interrupt_out    = do_take;
        pc_interrupt_sel = (do_take || do_pop || do_chain) ? PC_INTERRUPT : PC_NORMAL;
        int_addr         = '0;
        if (do_pop)                  int_addr = stack_pc[top_idx];
        else if (do_take || do_chain) int_addr = handler[winner];
    end

    // A fresh irq edge outranks the take clear, which outranks a CSR write.
    always_comb begin
        pend_next = pending;
        for (int i = 0; i < VecCount; i++) begin
            if (csr_we && cfg_sel[i]) pend_next[i] = csr_wdata[0];
            if ((do_take || do_chain) && winner == VecW'(i)) pend_next[i] = 1'b0;
            if (irq[i] && !irq_q[i]) pend_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            enable  <= '0;
            irq_q   <= '0;
            depth   <= '0;
            level   <= '0;
            for (int i = 0; i < VecCount; i++) begin
                prio[i]    <= '0;
                handler[i] <= '0;
            end
            for (int i = 0; i < StackDepth; i++) begin
                stack_pc[i]  <= '0;
                stack_lvl[i] <= '0;
            end
        end else begin
            irq_q   <= irq;
            pending <= pend_next;
            for (int i = 0; i < VecCount; i++) begin
                if (csr_we && cfg_sel[i]) begin
                    enable[i] <= csr_wdata[1];
                    prio[i]   <= csr_wdata[PrioWidth+1:2];
                end
                if (csr_we && vec_sel[i]) handler[i] <= csr_wdata[AddrWidth-1:0];
            end
            if (do_take) begin
                stack_pc[push_idx]  <= pc_in;
                stack_lvl[push_idx] <= level;
                depth               <= depth + 1'b1;
                level               <= prio[winner];
            end else if (do_chain) begin
                level <= prio[winner];
            end else if (do_pop) begin
                level <= stack_lvl[top_idx];
                depth <= depth - 1'b1;
            end
        end
    end
endmodule

// File: doc/n_clic_stack.md
Name: n_clic_stack

Overview:
- Parametrised successor to the single-level nested interrupt controller in the single-cycle core.
- Provides VecCount vectors, each with:
  - a pending bit, an enable bit and a priority;
  - a per-vector handler address.
- Preempts at the CSR decode stage. Keeps a hardware stack of return PC and previous level, StackDepth deep.
- Drives the PC interrupt mux, the register-file stack level and the return-address write.

Parameters:
- VecCount, 8, number of interrupt vectors (1..32).
- PrioWidth, 3, priority width. Level 0 is thread level.
- StackDepth, 4, maximum nesting depth (at most 2^PrioWidth-1).
- AddrWidth, 12, width of the PC and handler addresses.
- CsrBase, 12'hB00, address of vector-config CSR 0. Vector i is at CsrBase+i.
- CsrVecBase, 12'hB40, address of handler-address CSR 0. Vector i is at CsrVecBase+i.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- csr_enable  in  1  CSR instruction in decode
- csr_addr  in  12  CSR address
- csr_op  in  csr_op_t  RW/RS/RC and immediate forms
- rs1_zimm  in  5  zimm for the immediate forms
- rs1_data  in  32  rs1 operand
- irq  in  VecCount  external request lines, rising-edge sensitive
- ret  in  1  one-cycle pulse: the interrupt-return instruction is executing
- pc_in  in  AddrWidth  next PC from the branch mux
- csr_out  out  32  old CSR value (read-before-write); 0 for an unmapped address
- int_addr  out  AddrWidth  handler address, or the popped return PC
- pc_interrupt_sel  out  pc_interrupt_mux_t  selects int_addr for the PC
- level_out  out  PrioWidth  current running level
- interrupt_out  out  1  high during a take cycle; drives writeRaEn

Behaviour:
- Vector-config CSR layout: [0] pending, [1] enable, [PrioWidth+1:2] prio. Other bits read as 0 and ignore writes.
- Handler CSR: [AddrWidth-1:0] handler address. Other bits read as 0.
- Writes take effect at the clock edge.
- Operand is rs1_data for register forms and zero-extended rs1_zimm for immediate forms.
- RS/RC with a zero operand performs no write.
- irq is sampled into a registered copy. A 0->1 transition sets pending at the next edge.
- Arbitration is combinational from registered state:
  - eligible = pending & enable & (prio > level);
  - the highest prio wins; on a tie the lowest index wins.
- Take happens when an eligible vector exists, depth < StackDepth and ret=0. On a take cycle:
  - interrupt_out=1, pc_interrupt_sel=interrupt, int_addr=handler[winner];
  - at the edge: push {pc_in, level}, depth++, level<=prio[winner], pending[winner]<=0.
- Return happens when ret=1 and depth>0. On a return cycle:
  - pc_interrupt_sel=interrupt, int_addr=top.pc, interrupt_out=0;
  - at the edge: level<=top.level, depth--.
- ret with depth=0 is ignored: the PC is normal and no state changes.
- ret and an eligible vector in the same cycle: return wins and the take is re-evaluated next cycle. Exception: tail-chaining, see Optional Feature.
- Stack full (depth=StackDepth): no take. Pending bits are held.
- Same-cycle conflicts on the winner's pending bit:
  - take vs CSR write: the take clear wins; the other fields of that write still apply;
  - take vs irq edge: pending stays 1 (new event).
- A CSR write setting pending on an eligible vector is visible to arbitration the next cycle.
- level_out is registered and always equals level. Depth never wraps.
- Reset (asynchronous, any time, including mid-handler):
  - all pending, enable, prio and handler registers = 0, irq sampler = 0;
  - depth=0, level=0, stack cleared;
  - outputs: interrupt_out=0, pc_interrupt_sel=normal, int_addr=0, level_out=0, csr_out=0.

Optional Feature:
- Macro: N_CLIC_TAIL_CHAIN_EN.
- Enabled, when ret=1, depth>0 and a vector is eligible against top.level (not the current level):
  - no pop occurs: int_addr=handler[winner], interrupt_out=0 (the ra saved in the rf stack is kept);
  - at the edge: level<=prio[winner], pending[winner]<=0; the stack top is unchanged.
- Disabled: return always pops, as in Behaviour.

Test Plan:
- Reset mid-handler: depth=2, level=5, assert reset -> level_out=0, depth=0, pc_interrupt_sel=normal, all CSRs read 0.
- Single take and return:
  - setup: vec2 prio=3, en=1, handler=0x100; irq[2] rises with pc_in=0x040;
  - next cycle: int_addr=0x100, interrupt_out=1;
  - after the edge: level_out=3, pending[2]=0;
  - ret -> int_addr=0x040, then level_out=0.
- Nesting and masking:
  - in vec2 (level 3), pend vec5 prio=2 -> no take;
  - pend vec6 prio=6 -> take, level_out=6;
  - ret, ret -> PCs return in LIFO order.
- Tie arbitration: vec1 and vec4 both prio=4, pended in the same cycle -> vec1 taken first, then vec4 after the return.
- Stack full (StackDepth=4): four nested takes at prios 1, 2, 3, 4; vec at prio 7 pending -> no take until a ret; it is then taken from level 3.
- Tail chain: ret at level 6 with vec3 prio=2 pending and top.level=0:
  - macro enabled: int_addr=handler[3], level_out=2, depth unchanged;
  - macro disabled: pop to level 0, then take vec3 next cycle.
